wbcarbiter: RTL and testbench

Wishbone classic multi-master arbiter: the fan-in counterpart to the bus router. Up to NM masters (CPU, DMA, debug bridge) share one Wishbone classic slave-side port, which normally feeds the router. Round-robin grant, held for the full duration of the winning master's `cyc`. Optional bus watchdog terminates stalled cycles with an error.

---
 rtl/wbc_pkg.sv | 21 ++
 rtl/wbcarbiter_rrpick.sv | 37 +++
 rtl/wbcarbiter.sv | 154 +++++++++++++++
 tb/tb_wbcarbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbc_pkg.sv
// wbc_pkg: shared Wishbone classic definitions for the arbiter, router and
// decoder family.
//   WB_AW / WB_DW / WB_SW : default address, data and byte-select widths
//   idx_w(n)              : bits needed to index n items (never less than 1)
//   arb_state_e           : arbiter grant state (IDLE / BUSY)
package wbc_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = WB_DW / 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wbcarbiter_rrpick.sv
// wbcrrpick: combinational round-robin picker.
// Scans the request vector upward starting at last_i+1 (modulo NM) and
// returns the first requester found.
//   req_i   [NM-1:0] request vector
//   last_i  [IW-1:0] index of the previous winner
//   win_o   [IW-1:0] winning index (0 when valid_o is low)
//   valid_o          at least one request present
module wbcrrpick
    import wbc_pkg::*;
#(
    parameter int NM = 4,
    parameter int IW = idx_w(NM)
) (
    input  logic [NM-1:0] req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] win_o,
    output logic          valid_o
);

    logic [IW-1:0] cand;

    // Walk the offsets from farthest to nearest so the nearest requester
    // after last_i is the final (winning) assignment.
    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = NM; k >= 1; k--) begin
            cand = IW'((int'(last_i) + k) % NM);
            if (req_i[cand]) begin
                win_o   = cand;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wbcarbiter.sv
// wbcarbiter: Wishbone classic multi-master arbiter (NM masters -> 1 slave port).
// Round-robin grant, held for the whole of the winner's cyc; no preemption.
//
// Handshake: a master owns the bus while its cyc is high and it holds the
// grant; a transfer is offered when stb is high and completes in the cycle
// the slave returns ack (or err). The slave's ack/err/data are routed back
// combinationally to the granted master only.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_mcyc/i_mstb/i_mwe [NM]  per-master cycle, strobe, write enable
//   i_maddr/i_mdata/i_msel    per-master address/data/select, master k at [k*W +: W]
//   o_mack/o_merr [NM]        per-master ack/err, o_mdata per-master read data
//   o_scyc/o_sstb/o_swe       slave-side control
//   o_saddr/o_sdata/o_ssel    slave-side address, write data, byte selects
//   i_sack/i_serr/i_sdata     slave response
//   o_grant [NM]              registered one-hot grant, zero when idle
//
// Optional bus watchdog: define WBCARBITER_WATCHDOG_EN. A strobe stalled for
// TIMEOUT cycles is terminated with a one-cycle err to the granted master.
module wbcarbiter
    import wbc_pkg::*;
#(
    parameter int NM      = 4,
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int SW      = DW / 8,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NM-1:0]    i_mcyc,
    input  logic [NM-1:0]    i_mstb,
    input  logic [NM-1:0]    i_mwe,
    input  logic [NM*AW-1:0] i_maddr,
    input  logic [NM*DW-1:0] i_mdata,
    input  logic [NM*SW-1:0] i_msel,
    output logic [NM-1:0]    o_mack,
    output logic [NM-1:0]    o_merr,
    output logic [NM*DW-1:0] o_mdata,
    output logic             o_scyc,
    output logic             o_sstb,
    output logic             o_swe,
    output logic [AW-1:0]    o_saddr,
    output logic [DW-1:0]    o_sdata,
    output logic [SW-1:0]    o_ssel,
    input  logic             i_sack,
    input  logic             i_serr,
    input  logic [DW-1:0]    i_sdata,
    output logic [NM-1:0]    o_grant
);

    localparam int IW = idx_w(NM);

    arb_state_e    state_q;
    logic [IW-1:0] grant_idx_q;
    logic [IW-1:0] last_idx_q;
    logic [NM-1:0] grant_q;

    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic          base_cyc;
    logic          scyc_int;
    logic          sstb_int;
    logic          timeout_hit;

    wbcrrpick #(.NM(NM), .IW(IW)) u_pick (
        .req_i   (i_mcyc),
        .last_i  (last_idx_q),
        .win_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // The owner keeps the bus while its cyc stays high; any other cycle is an
    // arbitration point (idle, or the owner just dropped cyc).
    assign base_cyc = (state_q == ARB_BUSY) & i_mcyc[grant_idx_q];
    assign scyc_int = base_cyc & ~timeout_hit & ~i_reset;
    assign sstb_int = scyc_int & i_mstb[grant_idx_q];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ARB_IDLE;
            grant_idx_q <= '0;
            last_idx_q  <= IW'(NM - 1);
            grant_q     <= '0;
        end else if (!base_cyc) begin
            if (pick_valid) begin
                state_q     <= ARB_BUSY;
                grant_idx_q <= pick_idx;
                last_idx_q  <= pick_idx;
                grant_q     <= NM'(1) << pick_idx;
            end else begin
                state_q <= ARB_IDLE;
                grant_q <= '0;
            end
        end
    end

`ifdef WBCARBITER_WATCHDOG_EN
    localparam int CW = idx_w(TIMEOUT + 1);

    logic [CW-1:0] wd_q;
    logic [CW-1:0] wd_d;

    // Counts consecutive stalled strobes. On the timeout cycle sstb is
    // forced low, which clears the count at the following edge.
    always_comb begin
        wd_d = '0;
        if (sstb_int && !i_sack && !i_serr) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign timeout_hit = (wd_q == CW'(TIMEOUT)) & base_cyc & ~i_reset;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    assign o_grant = i_reset ? '0 : grant_q;

    always_comb begin
        o_scyc  = 1'b0;
        o_sstb  = 1'b0;
        o_swe   = 1'b0;
        o_saddr = '0;
        o_sdata = '0;
        o_ssel  = '0;
        o_mack  = '0;
        o_merr  = '0;
        o_mdata = '0;
        if (!i_reset && state_q == ARB_BUSY) begin
            o_scyc                          = scyc_int;
            o_sstb                          = sstb_int;
            o_swe                           = i_mwe[grant_idx_q];
            o_saddr                         = i_maddr[grant_idx_q*AW +: AW];
            o_sdata                         = i_mdata[grant_idx_q*DW +: DW];
            o_ssel                          = i_msel[grant_idx_q*SW +: SW];
            o_mack[grant_idx_q]             = i_sack & scyc_int;
            o_merr[grant_idx_q]             = (i_serr & scyc_int) | timeout_hit;
            o_mdata[grant_idx_q*DW +: DW]   = i_sdata;
        end
    end

endmodule

// File: tb/tb_wbcarbiter.sv
module tb_wbcarbiter;

    localparam int NM      = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = 4;
    localparam int TIMEOUT = 4;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             i_reset;
    logic [NM-1:0]    i_mcyc, i_mstb, i_mwe;
    logic [NM*AW-1:0] i_maddr;
    logic [NM*DW-1:0] i_mdata;
    logic [NM*SW-1:0] i_msel;
    logic [NM-1:0]    o_mack, o_merr;
    logic [NM*DW-1:0] o_mdata;
    logic             o_scyc, o_sstb, o_swe;
    logic [AW-1:0]    o_saddr;
    logic [DW-1:0]    o_sdata;
    logic [SW-1:0]    o_ssel;
    logic             i_sack, i_serr;
    logic [DW-1:0]    i_sdata;
    logic [NM-1:0]    o_grant;

    wbcarbiter #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_mcyc  (i_mcyc),
        .i_mstb  (i_mstb),
        .i_mwe   (i_mwe),
        .i_maddr (i_maddr),
        .i_mdata (i_mdata),
        .i_msel  (i_msel),
        .o_mack  (o_mack),
        .o_merr  (o_merr),
        .o_mdata (o_mdata),
        .o_scyc  (o_scyc),
        .o_sstb  (o_sstb),
        .o_swe   (o_swe),
        .o_saddr (o_saddr),
        .o_sdata (o_sdata),
        .o_ssel  (o_ssel),
        .i_sack  (i_sack),
        .i_serr  (i_serr),
        .i_sdata (i_sdata),
        .o_grant (o_grant)
    );

    // ---------------- vector types ----------------
    typedef struct {
        logic [NM-1:0] grant;
        logic          scyc;
        logic          sstb;
        logic [NM-1:0] mack;
        logic [NM-1:0] merr;
    } exp_t;

    typedef struct {
        logic          rst;
        logic [NM-1:0] mcyc;
        logic [NM-1:0] mstb;
        logic          sack;
        logic          serr;
        exp_t          e;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // sampled outputs from the most recent cycle
    logic [NM-1:0] s_grant, s_merr, s_mack;
    logic          s_sstb;
    exp_t          nil_e;

    // ---------------- reference model ----------------
    // Owner of the bus (-1 = nobody), round-robin pointer, stalled-strobe run.
    int m_owner = -1;
    int m_ptr   = NM - 1;
    int m_stall = 0;

    function automatic logic [AW-1:0] addr_of(input int k);
        return (k == 2) ? 32'h0000_0010 : 32'h0000_1000 * 32'(k + 1);
    endfunction

    function automatic logic [DW-1:0] data_of(input int k);
        return (k == 2) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | 32'(k));
    endfunction

    function automatic int onehot_idx(input logic [NM-1:0] g);
        for (int k = 0; k < NM; k++) if (g[k]) return k;
        return -1;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        logic cyc_ok, stb_ok, to;
        e.grant = '0; e.scyc = 1'b0; e.sstb = 1'b0; e.mack = '0; e.merr = '0;
        if (i_reset || m_owner < 0) return e;
        e.grant[m_owner] = 1'b1;
        cyc_ok = i_mcyc[m_owner];
        stb_ok = cyc_ok & i_mstb[m_owner];
        to = 1'b0;
`ifdef WBCARBITER_WATCHDOG_EN
        to = cyc_ok && (m_stall == TIMEOUT);
`endif
        e.scyc = cyc_ok & ~to;
        e.sstb = stb_ok & ~to;
        e.mack[m_owner] = i_sack & e.scyc;
        e.merr[m_owner] = (i_serr & e.scyc) | to;
        return e;
    endfunction

    // Advance the model across the coming clock edge.
    task automatic model_edge(input exp_t e);
        if (i_reset) begin
            m_owner = -1;
            m_ptr   = NM - 1;
            m_stall = 0;
        end else begin
            if (e.sstb && !i_sack && !i_serr) m_stall++;
            else m_stall = 0;
            if (m_owner < 0 || !i_mcyc[m_owner]) begin
                m_owner = -1;
                for (int k = 1; k <= NM; k++) begin
                    int c;
                    c = (m_ptr + k) % NM;
                    if (i_mcyc[c]) begin
                        m_owner = c;
                        m_ptr   = c;
                        break;
                    end
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic cmp(input string tag, input string field,
                       input logic [127:0] act, input logic [127:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h (t=%0t)", tag, field, act, exp, $time);
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        cmp(tag, "value", act, exp);
    endtask

    task automatic check(input string tag, input exp_t e);
        int            o;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [SW-1:0] es;
        logic          ew;
        logic [NM*DW-1:0] em;
        n_vec++;
        o  = onehot_idx(e.grant);
        ea = '0; ed = '0; es = '0; ew = 1'b0; em = '0;
        if (o >= 0) begin
            ea = addr_of(o);
            ed = data_of(o);
            es = SW'(o + 1);
            ew = i_mwe[o];
            em[o*DW +: DW] = i_sdata;
        end
        cmp(tag, "grant", o_grant, e.grant);
        cmp(tag, "scyc",  o_scyc,  e.scyc);
        cmp(tag, "sstb",  o_sstb,  e.sstb);
        cmp(tag, "mack",  o_mack,  e.mack);
        cmp(tag, "merr",  o_merr,  e.merr);
        cmp(tag, "swe",   o_swe,   ew);
        cmp(tag, "saddr", o_saddr, ea);
        cmp(tag, "sdata", o_sdata, ed);
        cmp(tag, "ssel",  o_ssel,  es);
        cmp(tag, "mdata", o_mdata, em);
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1; drives one cycle, checks mid-cycle, returns at next posedge+1.
    task automatic apply(input logic rst, input logic [NM-1:0] cyc, input logic [NM-1:0] stb,
                         input logic ack, input logic err, input logic use_tbl,
                         input exp_t te, input string tag);
        exp_t me;
        i_reset = rst;
        i_mcyc  = cyc;
        i_mstb  = stb;
        i_sack  = ack;
        i_serr  = err;
        #4;
        me = model_expect();
        check(tag, use_tbl ? te : me);
        s_grant = o_grant;
        s_merr  = o_merr;
        s_mack  = o_mack;
        s_sstb  = o_sstb;
        model_edge(me);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rst, input logic [3:0] cyc, input logic [3:0] stb,
                                input logic ack, input logic err, input logic [3:0] g,
                                input logic sc, input logic ss, input logic [3:0] ma,
                                input logic [3:0] me);
        vec_t v;
        v.rst = rst; v.mcyc = cyc; v.mstb = stb; v.sack = ack; v.serr = err;
        v.e.grant = g; v.e.scyc = sc; v.e.sstb = ss; v.e.mack = ma; v.e.merr = me;
        return v;
    endfunction

    // ---------------- test ----------------
    vec_t tbl[19];

    initial begin
        int            cnt, pos;
        logic          pos_sstb;
        logic [NM-1:0] want, stb;

        nil_e.grant = '0; nil_e.scyc = 1'b0; nil_e.sstb = 1'b0; nil_e.mack = '0; nil_e.merr = '0;

        //           rst cyc      stb      ack  err  grant    scyc stb  mack     merr
        tbl[0]  = mk(1, 4'b0000, 4'b0000, 0,   0,   4'b0000, 0,   0,   4'b0000, 4'b0000); // reset
        tbl[1]  = mk(0, 4'b0100, 4'b0100, 0,   0,   4'b0000, 0,   0,   4'b0000, 4'b0000); // m2 request
        tbl[2]  = mk(0, 4'b0100, 4'b0100, 1,   0,   4'b0100, 1,   1,   4'b0100, 4'b0000); // m2 write ack
        tbl[3]  = mk(0, 4'b0000, 4'b0000, 0,   0,   4'b0100, 0,   0,   4'b0000, 4'b0000); // m2 drops
        tbl[4]  = mk(0, 4'b0000, 4'b0000, 0,   0,   4'b0000, 0,   0,   4'b0000, 4'b0000); // idle
        tbl[5]  = mk(1, 4'b1011, 4'b1011, 0,   0,   4'b0000, 0,   0,   4'b0000, 4'b0000); // reset, 0/1/3 waiting
        tbl[6]  = mk(0, 4'b1011, 4'b1011, 0,   0,   4'b0000, 0,   0,   4'b0000, 4'b0000);
        tbl[7]  = mk(0, 4'b1011, 4'b1011, 1,   0,   4'b0001, 1,   1,   4'b0001, 4'b0000); // m0 ack
        tbl[8]  = mk(0, 4'b1010, 4'b1010, 0,   0,   4'b0001, 0,   0,   4'b0000, 4'b0000); // m0 drops
        tbl[9]  = mk(0, 4'b1010, 4'b1010, 1,   0,   4'b0010, 1,   1,   4'b0010, 4'b0000); // m1 ack
        tbl[10] = mk(0, 4'b1000, 4'b1000, 0,   0,   4'b0010, 0,   0,   4'b0000, 4'b0000); // m1 drops
        tbl[11] = mk(0, 4'b1001, 4'b1001, 1,   0,   4'b1000, 1,   1,   4'b1000, 4'b0000); // m3 ack, m0 back
        tbl[12] = mk(0, 4'b0001, 4'b0001, 0,   0,   4'b1000, 0,   0,   4'b0000, 4'b0000); // m3 drops
        tbl[13] = mk(0, 4'b0001, 4'b0001, 0,   0,   4'b0001, 1,   1,   4'b0000, 4'b0000); // m0 again
        tbl[14] = mk(0, 4'b0010, 4'b0010, 1,   0,   4'b0001, 0,   0,   4'b0000, 4'b0000); // ack with cyc drop
        tbl[15] = mk(0, 4'b0010, 4'b0010, 0,   0,   4'b0010, 1,   1,   4'b0000, 4'b0000); // handed to m1
        tbl[16] = mk(0, 4'b0010, 4'b0000, 0,   1,   4'b0010, 1,   0,   4'b0000, 4'b0010); // slave err
        tbl[17] = mk(0, 4'b0000, 4'b0000, 0,   0,   4'b0010, 0,   0,   4'b0000, 4'b0000);
        tbl[18] = mk(0, 4'b0000, 4'b0000, 0,   0,   4'b0000, 0,   0,   4'b0000, 4'b0000);

        i_reset = 1'b1; i_mcyc = '0; i_mstb = '0; i_sack = 1'b0; i_serr = 1'b0;
        i_mwe   = 4'b0101;
        i_sdata = 32'h1234_5678;
        for (int k = 0; k < NM; k++) begin
            i_maddr[k*AW +: AW] = addr_of(k);
            i_mdata[k*DW +: DW] = data_of(k);
            i_msel[k*SW +: SW]  = SW'(k + 1);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].rst, tbl[i].mcyc, tbl[i].mstb, tbl[i].sack, tbl[i].serr,
                  1'b1, tbl[i].e, $sformatf("tbl%0d", i));
        end

        // No preemption: m1 stalled 5 cycles, m0 arrives mid-cycle.
        apply(0, 4'b0010, 4'b0010, 0, 0, 0, nil_e, "np_req");
        for (int i = 0; i < 5; i++) begin
            apply(0, (i >= 1) ? 4'b0011 : 4'b0010, (i >= 1) ? 4'b0011 : 4'b0010, 0, 0, 0, nil_e, "np_stall");
            chk("np_hold", s_grant, 4'b0010);
        end
        apply(0, 4'b0011, 4'b0011, 1, 0, 0, nil_e, "np_ack");
        chk("np_ack_m1", s_mack, 4'b0010);
        apply(0, 4'b0001, 4'b0001, 0, 0, 0, nil_e, "np_drop");
        chk("np_drop_grant", s_grant, 4'b0010);
        apply(0, 4'b0001, 4'b0001, 1, 0, 0, nil_e, "np_m0");
        chk("np_m0_grant", s_grant, 4'b0001);
        apply(0, 4'b0000, 4'b0000, 0, 0, 0, nil_e, "np_rel");
        apply(0, 4'b0000, 4'b0000, 0, 0, 0, nil_e, "np_idle");

        // Reset in the middle of a stalled transfer.
        apply(0, 4'b0001, 4'b0001, 0, 0, 0, nil_e, "rs_req");
        apply(0, 4'b0001, 4'b0001, 0, 0, 0, nil_e, "rs_stall");
        chk("rs_granted", s_grant, 4'b0001);
        apply(1, 4'b0001, 4'b0001, 1, 0, 0, nil_e, "rs_reset");
        chk("rs_reset_grant", s_grant, 4'b0000);
        chk("rs_reset_mack", s_mack, 4'b0000);
        apply(0, 4'b0001, 4'b0001, 1, 0, 0, nil_e, "rs_after");
        chk("rs_after_grant", s_grant, 4'b0000);
        chk("rs_after_mack", s_mack, 4'b0000);
        apply(0, 4'b0001, 4'b0001, 1, 0, 0, nil_e, "rs_regain");
        chk("rs_regain_grant", s_grant, 4'b0001);
        apply(0, 4'b0000, 4'b0000, 0, 0, 0, nil_e, "rs_rel");
        apply(0, 4'b0000, 4'b0000, 0, 0, 0, nil_e, "rs_idle");

        // Slave that never responds: m3 strobes for 7 cycles after its grant.
        cnt = 0; pos = -1; pos_sstb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            apply(0, 4'b1000, 4'b1000, 0, 0, 0, nil_e, "wd_stall");
            if (i >= 1 && s_merr[3]) begin
                cnt++;
                if (pos < 0) begin
                    pos      = i;
                    pos_sstb = s_sstb;
                end
            end
        end
`ifdef WBCARBITER_WATCHDOG_EN
        chk("wd_err_count", cnt, 1);
        chk("wd_err_pos", pos, 5);
        chk("wd_err_sstb", pos_sstb, 1'b0);
`else
        chk("wd_err_count", cnt, 0);
`endif
        apply(0, 4'b0000, 4'b0000, 0, 0, 0, nil_e, "wd_rel");
        apply(0, 4'b0000, 4'b0000, 0, 0, 0, nil_e, "wd_idle");

        // Randomised traffic against the model.
        want = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < NM; k++) begin
                if (want[k]) want[k] = ($urandom_range(0, 5) != 0);
                else         want[k] = ($urandom_range(0, 4) == 0);
                stb[k] = want[k] & ($urandom_range(0, 3) != 0);
            end
            i_sdata = $urandom;
            apply(($urandom_range(0, 299) == 0), want, stb,
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0),
                  0, nil_e, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
